// File: rtl/ravenoc_pkg.sv
// Shared NoC types and default widths for the flit transmitter and its neighbours.
`timescale 1ns/1ps
package ravenoc_pkg;

  localparam int NOC_X_WIDTH         = 2;
  localparam int NOC_Y_WIDTH         = 2;
  localparam int NOC_PKT_WIDTH       = 8;
  localparam int NOC_FLIT_WIDTH      = 34;
  localparam int FLIT_TYPE_WIDTH     = 2;
  localparam int NOC_FLIT_DATA_WIDTH = NOC_FLIT_WIDTH - FLIT_TYPE_WIDTH;
  localparam int NOC_HEAD_DATA_WIDTH = NOC_FLIT_DATA_WIDTH - NOC_X_WIDTH - NOC_Y_WIDTH
                                     - NOC_PKT_WIDTH;

  // pkt_size counts flits after the head, so a lone head carries zero.
  localparam logic [NOC_PKT_WIDTH-1:0] MIN_SIZE_FLIT = '0;

  typedef enum logic [FLIT_TYPE_WIDTH-1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  typedef struct packed {
    flit_type_t                     type_f;
    logic [NOC_X_WIDTH-1:0]         x_dest;
    logic [NOC_Y_WIDTH-1:0]         y_dest;
    logic [NOC_PKT_WIDTH-1:0]       pkt_size;
    logic [NOC_HEAD_DATA_WIDTH-1:0] data;
  } s_flit_head_data_t;

  typedef struct packed {
    flit_type_t                     type_f;
    logic [NOC_FLIT_DATA_WIDTH-1:0] data;
  } s_flit_data_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } tx_state_t;

endpackage

// File: rtl/vc_flit_tx.sv
// Packetizer: turns a request plus payload beats into HEAD/BODY/TAIL flits
// through a single registered output stage with full-throughput backpressure.
`timescale 1ns/1ps
module vc_flit_tx
  import ravenoc_pkg::*;
#(
  parameter int X_WIDTH    = NOC_X_WIDTH,
  parameter int Y_WIDTH    = NOC_Y_WIDTH,
  parameter int PKT_WIDTH  = NOC_PKT_WIDTH,
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             arst_n,
  input  logic                                             req_valid_i,
  output logic                                             req_ready_o,
  input  logic [X_WIDTH-1:0]                               req_x_i,
  input  logic [Y_WIDTH-1:0]                               req_y_i,
  input  logic [PKT_WIDTH-1:0]                             req_len_i,
  input  logic [FLIT_WIDTH-2-X_WIDTH-Y_WIDTH-PKT_WIDTH-1:0] req_hdata_i,
  input  logic                                             data_valid_i,
  output logic                                             data_ready_o,
  input  logic [FLIT_WIDTH-2-1:0]                          data_i,
  output logic [FLIT_WIDTH-1:0]                            fdata_o,
  output logic                                             valid_o,
  input  logic                                             ready_i,
  output logic                                             busy_o
);

  tx_state_t             state_q, state_d;
  logic [PKT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [FLIT_WIDTH-1:0] fdata_q, fdata_d;
  logic                  valid_q, valid_d;
  logic                  out_free;
  logic                  last_beat;
  flit_type_t            beat_type;

  // The output register can take a new flit if empty or draining this cycle.
  assign out_free  = ~valid_q | ready_i;
  assign last_beat = (cnt_q == PKT_WIDTH'(1));
  assign beat_type = last_beat ? TAIL_FLIT : BODY_FLIT;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    fdata_d      = fdata_q;
    valid_d      = valid_q & ~ready_i;
    req_ready_o  = 1'b0;
    data_ready_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = out_free;
        if (req_valid_i && out_free) begin
          fdata_d = {HEAD_FLIT, req_x_i, req_y_i, req_len_i, req_hdata_i};
          valid_d = 1'b1;
          if (req_len_i != PKT_WIDTH'(MIN_SIZE_FLIT)) begin
            cnt_d   = req_len_i;
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        data_ready_o = out_free;
        if (data_valid_i && out_free) begin
          fdata_d = {beat_type, data_i};
          valid_d = 1'b1;
          cnt_d   = cnt_q - PKT_WIDTH'(1);
          if (last_beat) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: sequential state uses non-blocking assignments; everything here is reset,
    // so an abandoned partial packet leaves no residue in the counter or output.
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fdata_q <= fdata_d;
      valid_q <= valid_d;
    end
  end

  assign fdata_o = fdata_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == ST_BODY);

`ifndef NO_ASSERTIONS
  a_hold_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (valid_q && !ready_i) |=> (valid_q && $stable(fdata_q)));

  a_cnt_nonzero: assert property (@(posedge clk) disable iff (!arst_n)
    (state_q == ST_BODY) |-> (cnt_q != '0));

  a_no_head_in_body: assert property (@(posedge clk) disable iff (!arst_n)
    (state_q == ST_BODY && data_valid_i && out_free)
      |=> (fdata_q[FLIT_WIDTH-1 -: 2] != HEAD_FLIT));
`endif

endmodule

// File: doc/vc_flit_tx.md
Name: vc_flit_tx

Overview:
- Flit transmitter (packetizer) feeding a virtual channel buffer's input interface (fdata/valid/ready).
- Takes a packet request (destination, length, head payload) plus a stream of payload beats.
- Emits HEAD, then BODY, then TAIL flits. A single-flit packet is emitted as a lone HEAD with pkt_size == MIN_SIZE_FLIT.
- Sits in the local NI / input module in front of each router input VC. Guarantees the head/tail framing the VC lock logic relies on.

Parameters:
X_WIDTH, 2, destination X coordinate width
Y_WIDTH, 2, destination Y coordinate width
PKT_WIDTH, 8, pkt_size field width (flits following head; 0 = MIN_SIZE_FLIT)
FLIT_WIDTH, 34, total flit width (2-bit type + 32-bit payload)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  packet request valid
req_ready_o  out  1  packet request accepted when high with req_valid_i
req_x_i  in  X_WIDTH  destination X
req_y_i  in  Y_WIDTH  destination Y
req_len_i  in  PKT_WIDTH  number of flits after head
req_hdata_i  in  FLIT_WIDTH-2-X_WIDTH-Y_WIDTH-PKT_WIDTH  head flit payload
data_valid_i  in  1  payload beat valid
data_ready_o  out  1  payload beat accepted when high with data_valid_i
data_i  in  FLIT_WIDTH-2  payload beat
fdata_o  out  FLIT_WIDTH  flit to VC buffer
valid_o  out  1  flit valid
ready_i  in  1  VC buffer ready
busy_o  out  1  high while a multi-flit packet is in progress (state BODY)

Behaviour:
- Reset (arst_n low, asynchronous):
  - state=IDLE, cnt=0, valid_o=0, fdata_o=0, busy_o=0, data_ready_o=0.
  - req_ready_o=1, because it is combinational from IDLE plus an empty output register.
- Output register: fdata_o/valid_o are registered. out_free = ~valid_o | ready_i.
  - valid_o deasserts only after ready_i handshake with no new load.
  - fdata_o/valid_o must stay stable while valid_o & ~ready_i.
- FSM states IDLE and BODY; down-counter cnt is PKT_WIDTH wide.
- IDLE:
  - req_ready_o = out_free; data_ready_o = 0; data_valid_i ignored.
  - On req_valid_i & out_free: load {HEAD_FLIT, req_x_i, req_y_i, req_len_i, req_hdata_i}; valid_o=1 next cycle.
  - If req_len_i == 0: stay IDLE (single-flit packet, no TAIL).
  - Else: cnt<=req_len_i, go BODY.
- BODY:
  - req_ready_o = 0; data_ready_o = out_free.
  - On data_valid_i & out_free: load {cnt==1 ? TAIL_FLIT : BODY_FLIT, data_i}; cnt<=cnt-1.
  - If cnt==1, go IDLE.
- Latency: accepted request or beat appears on fdata_o the next cycle.
- Throughput: one flit per cycle sustained, including back-to-back packets. TAIL loaded in cycle N allows a HEAD accept in cycle N+1 with no bubble.
- Backpressure: ready_i low with valid_o high blocks all loads (req_ready_o=data_ready_o=0). No flit is dropped or duplicated.
- Input bubbles: data_valid_i low in BODY holds state and cnt. valid_o falls after the pending flit drains.
- Maximum length: req_len_i=2^PKT_WIDTH-1 yields 2^PKT_WIDTH flits total; the counter never wraps.
- Reset mid-packet: partial packet is abandoned and the FSM returns to IDLE. The downstream VC shares the reset domain, so its lock is cleared simultaneously.
- Assertions (guarded by NO_ASSERTIONS):
  - fdata_o stable while valid_o & ~ready_i.
  - cnt != 0 in BODY.
  - No HEAD emitted while in BODY.

Decomposition:
- ravenoc_pkg receives:
  - flit type enum (HEAD_FLIT, BODY_FLIT, TAIL_FLIT).
  - MIN_SIZE_FLIT.
  - s_flit_head_data_t (type_f, x_dest, y_dest, pkt_size, data).
  - s_flit_data_t (type_f, data).
  - FSM state enum.
- Widths derive from package constants; module parameters default to them.
- No sub-module is needed: the output register and FSM are compact, and the team's existing fifo may be placed upstream by the integrator if decoupling is needed.

Test Plan:
- Single-flit: req x=1, y=2, len=0, hdata=0x5A, ready_i=1 -> one HEAD, pkt_size=0, valid_o for exactly 1 cycle, cycle after accept; busy_o stays 0; data_ready_o never 1.
- 4-flit packet: len=3, beats 0xA,0xB,0xC -> HEAD(pkt_size=3), BODY(0xA), BODY(0xB), TAIL(0xC) on consecutive cycles; busy_o high for exactly 3 cycles.
- Backpressure: ready_i low 5 cycles while HEAD pending -> fdata_o/valid_o unchanged; req_ready_o=data_ready_o=0; sequence completes intact after release.
- Back-to-back: two len=1 packets with req_valid_i held -> HEAD,TAIL,HEAD,TAIL on 4 consecutive cycles, no bubble.
- Data bubbles: len=2, data_valid_i toggled 1,0,0,1 -> BODY then TAIL, order preserved; cnt held during gaps; no extra flits.
- Reset mid-packet: arst_n low after HEAD + 1 BODY of len=5 -> valid_o=0 immediately, state IDLE, req_ready_o=1 after release; next len=0 request emits a clean HEAD.
